// File: rtl/core_pkg.sv
// Shared core definitions: widths, the fetch FSM encoding, the NOP word and the base
// opcodes that the fetch, sign-extend and control blocks all agree on.
package core_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [6:0] OPC_LOAD      = 7'h03;
    localparam logic [6:0] OPC_OP_IMM    = 7'h13;
    localparam logic [6:0] OPC_AUIPC     = 7'h17;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
    localparam logic [6:0] OPC_STORE     = 7'h23;
    localparam logic [6:0] OPC_OP        = 7'h33;
    localparam logic [6:0] OPC_LUI       = 7'h37;
    localparam logic [6:0] OPC_OP_32     = 7'h3B;
    localparam logic [6:0] OPC_BRANCH    = 7'h63;
    localparam logic [6:0] OPC_JALR      = 7'h67;
    localparam logic [6:0] OPC_JAL       = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM    = 7'h73;

    // Instruction fetch targets must be word aligned; only the two low bits matter.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register: async reset to RESET_PC, load wins over increment-by-4.
module pc_reg #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_val_i,
    input  logic            inc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Next PC selection; the increment wraps naturally at 2^XLEN.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + {{(XLEN-3){1'b0}}, 3'b100};
        end else begin
            pc_d = pc_q;
        end
    end

    // PC storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to instruction memory, latches the IR,
// and handles redirects (including discarding in-flight responses) and misaligned targets.
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          XLEN     = 64,
    parameter int          ILEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            ir_valid,
    input  logic            ir_ready,
    output logic [ILEN-1:0] ir,
    output logic [XLEN-1:0] ir_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_misalign
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc_s;
    logic            pc_load_s;
    logic            pc_inc_s;
    logic            ir_load_s;
    logic            handshake_s;
    logic            req_valid_q;
    logic            ir_valid_q;
    logic            misalign_q;
    logic [ILEN-1:0] ir_q;
    logic [XLEN-1:0] ir_pc_q;

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC[XLEN-1:0])
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (pc_load_s),
        .load_val_i (redirect_pc),
        .inc_i      (pc_inc_s),
        .pc_o       (pc_s)
    );

    assign handshake_s = req_valid_q & imem_req_ready;

    // Next-state logic; a redirect overrides every other event in the same cycle.
    always_comb begin
        state_d   = state_q;
        pc_load_s = 1'b0;
        pc_inc_s  = 1'b0;
        ir_load_s = 1'b0;
        if (redirect_valid) begin
            pc_load_s = 1'b1;
            if (!is_word_aligned(redirect_pc[1:0])) begin
                state_d = S_FAULT;
            end else begin
                case (state_q)
                    S_REQ:   state_d = handshake_s ? S_DRAIN : S_REQ;
                    S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                    S_HOLD:  state_d = S_REQ;
                    S_DRAIN: state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                    S_FAULT: state_d = S_REQ;
                    default: state_d = S_REQ;
                endcase
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    state_d = handshake_s ? S_WAIT : S_REQ;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        ir_load_s = 1'b1;
                        pc_inc_s  = 1'b1;
                        state_d   = S_HOLD;
                    end else begin
                        state_d   = S_WAIT;
                    end
                end
                S_HOLD:  state_d = ir_ready ? S_REQ : S_HOLD;
                S_DRAIN: state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_REQ;
            endcase
        end
    end

    // State and registered status outputs, all decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b0;
            ir_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= (state_d == S_REQ);
            ir_valid_q  <= (state_d == S_HOLD);
            misalign_q  <= (state_d == S_FAULT);
        end
    end

    // Instruction register and the PC it was fetched from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q    <= NOP_INSTR;
            ir_pc_q <= {XLEN{1'b0}};
        end else if (ir_load_s) begin
            ir_q    <= imem_rsp_data;
            ir_pc_q <= pc_s;
        end else begin
            ir_q    <= ir_q;
            ir_pc_q <= ir_pc_q;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_s;
    assign ir_valid       = ir_valid_q;
    assign ir             = ir_q;
    assign ir_pc          = ir_pc_q;
    assign fetch_misalign = misalign_q;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scenario bench for instr_fetch_unit with a scoreboard of expected IR contents.
module tb_instr_fetch_unit;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [63:0] ir_pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_misalign;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] last_ir;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .opcode         (opcode),
        .rd             (rd),
        .funct3         (funct3),
        .rs1            (rs1),
        .rs2            (rs2),
        .funct7         (funct7),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    // A response may only arrive while the DUT is waiting, draining or faulted.
    always @(posedge clk) begin
        if (rst_n && imem_rsp_valid) begin
            compared++;
            if (!(dut.state_q inside {S_WAIT, S_DRAIN, S_FAULT})) begin
                mismatched++;
                $display("FAIL rsp_protocol: response in state %0d, required WAIT/DRAIN/FAULT", dut.state_q);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, accept it, answer one cycle later, push the expectation.
    task automatic issue(input logic [31:0] data, input logic [63:0] exp_pc,
                         output logic [63:0] addr, output bit ok);
        ok = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (imem_req_valid) ok = 1'b1;
            else tick();
        end
        addr = imem_addr;
        exp_q.push_back('{instr: data, pc: exp_pc});
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        compared += 6;
        if (imem_req_valid !== 1'b0) begin mismatched++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        if (ir_valid !== 1'b0) begin mismatched++; $display("FAIL rst_ir_valid: got %b want 0", ir_valid); end
        if (ir !== 32'h0000_0013) begin mismatched++; $display("FAIL rst_ir: got %h want 00000013", ir); end
        if (ir_pc !== 64'h0) begin mismatched++; $display("FAIL rst_ir_pc: got %h want 0", ir_pc); end
        if (fetch_misalign !== 1'b0) begin mismatched++; $display("FAIL rst_misalign: got %b want 0", fetch_misalign); end
        if (imem_addr !== 64'h0) begin mismatched++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compared++;
        if (imem_req_valid !== 1'b0) begin mismatched++; $display("FAIL rst_release_early: got %b want 0", imem_req_valid); end
        tick();
        compared += 2;
        if (imem_req_valid !== 1'b1) begin mismatched++; $display("FAIL rst_first_req: got %b want 1", imem_req_valid); end
        if (imem_addr !== 64'h0) begin mismatched++; $display("FAIL rst_first_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_basic_fetch();
        logic [63:0] addr;
        bit          ok;
        exp_t        e;
        issue(32'h00A0_0093, 64'h0, addr, ok);
        compared += 3;
        if (!ok) begin mismatched++; $display("FAIL basic_req_timeout: got none want request"); end
        if (addr !== 64'h0) begin mismatched++; $display("FAIL basic_addr: got %h want 0", addr); end
        if (ir_valid !== 1'b1) begin mismatched++; $display("FAIL basic_ir_valid: got %b want 1", ir_valid); end
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++; $display("FAIL basic_scoreboard: got empty want entry");
        end else begin
            e = exp_q.pop_front();
            compared += 6;
            if (ir !== e.instr) begin mismatched++; $display("FAIL basic_ir: got %h want %h", ir, e.instr); end
            if (ir_pc !== e.pc) begin mismatched++; $display("FAIL basic_ir_pc: got %h want %h", ir_pc, e.pc); end
            if (rd !== 5'd1) begin mismatched++; $display("FAIL basic_rd: got %0d want 1", rd); end
            if (opcode !== 7'h13) begin mismatched++; $display("FAIL basic_opcode: got %h want 13", opcode); end
            if (rs1 !== 5'd0) begin mismatched++; $display("FAIL basic_rs1: got %0d want 0", rs1); end
            if (funct3 !== 3'd0) begin mismatched++; $display("FAIL basic_funct3: got %0d want 0", funct3); end
        end
        last_ir = 32'h00A0_0093;
        for (int i = 0; i < 5; i++) begin
            tick();
            compared += 4;
            if (ir !== 32'h00A0_0093) begin mismatched++; $display("FAIL hold_ir: got %h want 00a00093", ir); end
            if (ir_pc !== 64'h0) begin mismatched++; $display("FAIL hold_ir_pc: got %h want 0", ir_pc); end
            if (ir_valid !== 1'b1) begin mismatched++; $display("FAIL hold_ir_valid: got %b want 1", ir_valid); end
            if (imem_req_valid !== 1'b0) begin mismatched++; $display("FAIL hold_no_req: got %b want 0", imem_req_valid); end
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        compared += 3;
        if (ir_valid !== 1'b0) begin mismatched++; $display("FAIL release_ir_valid: got %b want 0", ir_valid); end
        if (imem_req_valid !== 1'b1) begin mismatched++; $display("FAIL release_req: got %b want 1", imem_req_valid); end
        if (imem_addr !== 64'h4) begin mismatched++; $display("FAIL release_addr: got %h want 4", imem_addr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] instrs [3] = '{32'h0020_81B3, 32'h40B5_0533, 32'hFFF2_C293};
        logic [63:0] exp_pc = 64'h4;
        logic [63:0] addr;
        bit          ok;
        exp_t        e;
        for (int i = 0; i < 3; i++) begin
            issue(instrs[i], exp_pc, addr, ok);
            compared += 3;
            if (!ok) begin mismatched++; $display("FAIL b2b_req_timeout[%0d]: got none want request", i); end
            if (addr !== exp_pc) begin mismatched++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, addr, exp_pc); end
            if (ir_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_ir_valid[%0d]: got %b want 1", i, ir_valid); end
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++; $display("FAIL b2b_scoreboard[%0d]: got empty want entry", i);
            end else begin
                e = exp_q.pop_front();
                compared += 8;
                if (ir !== e.instr) begin mismatched++; $display("FAIL b2b_ir[%0d]: got %h want %h", i, ir, e.instr); end
                if (ir_pc !== e.pc) begin mismatched++; $display("FAIL b2b_ir_pc[%0d]: got %h want %h", i, ir_pc, e.pc); end
                if (opcode !== e.instr[6:0]) begin mismatched++; $display("FAIL b2b_opcode[%0d]: got %h want %h", i, opcode, e.instr[6:0]); end
                if (rd !== e.instr[11:7]) begin mismatched++; $display("FAIL b2b_rd[%0d]: got %h want %h", i, rd, e.instr[11:7]); end
                if (funct3 !== e.instr[14:12]) begin mismatched++; $display("FAIL b2b_funct3[%0d]: got %h want %h", i, funct3, e.instr[14:12]); end
                if (rs1 !== e.instr[19:15]) begin mismatched++; $display("FAIL b2b_rs1[%0d]: got %h want %h", i, rs1, e.instr[19:15]); end
                if (rs2 !== e.instr[24:20]) begin mismatched++; $display("FAIL b2b_rs2[%0d]: got %h want %h", i, rs2, e.instr[24:20]); end
                if (funct7 !== e.instr[31:25]) begin mismatched++; $display("FAIL b2b_funct7[%0d]: got %h want %h", i, funct7, e.instr[31:25]); end
            end
            last_ir = instrs[i];
            ir_ready = 1'b1;
            tick();
            ir_ready = 1'b0;
            exp_pc = exp_pc + 64'h4;
        end
        compared += 2;
        if (imem_req_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_next_req: got %b want 1", imem_req_valid); end
        if (imem_addr !== 64'h10) begin mismatched++; $display("FAIL b2b_next_addr: got %h want 10", imem_addr); end
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        tick();
        redirect_valid = 1'b0;
        compared += 2;
        if (imem_req_valid !== 1'b0) begin mismatched++; $display("FAIL drain_no_req: got %b want 0", imem_req_valid); end
        if (ir_valid !== 1'b0) begin mismatched++; $display("FAIL drain_ir_valid: got %b want 0", ir_valid); end
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        compared += 4;
        if (ir !== last_ir) begin mismatched++; $display("FAIL drain_ir_kept: got %h want %h", ir, last_ir); end
        if (ir_valid !== 1'b0) begin mismatched++; $display("FAIL drain_ir_valid_after: got %b want 0", ir_valid); end
        if (imem_req_valid !== 1'b1) begin mismatched++; $display("FAIL drain_next_req: got %b want 1", imem_req_valid); end
        if (imem_addr !== 64'h100) begin mismatched++; $display("FAIL drain_next_addr: got %h want 100", imem_addr); end
    endtask

    task automatic test_redirect_same_cycle();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h180;
        tick();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        compared += 4;
        if (ir !== last_ir) begin mismatched++; $display("FAIL same_ir_kept: got %h want %h", ir, last_ir); end
        if (ir_valid !== 1'b0) begin mismatched++; $display("FAIL same_ir_valid: got %b want 0", ir_valid); end
        if (imem_req_valid !== 1'b1) begin mismatched++; $display("FAIL same_next_req: got %b want 1", imem_req_valid); end
        if (imem_addr !== 64'h180) begin mismatched++; $display("FAIL same_next_addr: got %h want 180", imem_addr); end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h102;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            compared += 3;
            if (fetch_misalign !== 1'b1) begin mismatched++; $display("FAIL fault_flag[%0d]: got %b want 1", i, fetch_misalign); end
            if (imem_req_valid !== 1'b0) begin mismatched++; $display("FAIL fault_no_req[%0d]: got %b want 0", i, imem_req_valid); end
            if (ir_valid !== 1'b0) begin mismatched++; $display("FAIL fault_ir_valid[%0d]: got %b want 0", i, ir_valid); end
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        tick();
        redirect_valid = 1'b0;
        compared += 3;
        if (fetch_misalign !== 1'b0) begin mismatched++; $display("FAIL fault_clear: got %b want 0", fetch_misalign); end
        if (imem_req_valid !== 1'b1) begin mismatched++; $display("FAIL fault_resume_req: got %b want 1", imem_req_valid); end
        if (imem_addr !== 64'h200) begin mismatched++; $display("FAIL fault_resume_addr: got %h want 200", imem_addr); end
        // Misaligned redirect with a response still owed: it must be absorbed in the fault state.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h206;
        tick();
        redirect_valid = 1'b0;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        tick();
        imem_rsp_valid = 1'b0;
        compared += 3;
        if (ir !== last_ir) begin mismatched++; $display("FAIL absorb_ir_kept: got %h want %h", ir, last_ir); end
        if (fetch_misalign !== 1'b1) begin mismatched++; $display("FAIL absorb_flag: got %b want 1", fetch_misalign); end
        if (imem_req_valid !== 1'b0) begin mismatched++; $display("FAIL absorb_no_req: got %b want 0", imem_req_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h300;
        tick();
        redirect_valid = 1'b0;
        compared += 3;
        if (fetch_misalign !== 1'b0) begin mismatched++; $display("FAIL absorb_clear: got %b want 0", fetch_misalign); end
        if (imem_req_valid !== 1'b1) begin mismatched++; $display("FAIL absorb_resume_req: got %b want 1", imem_req_valid); end
        if (imem_addr !== 64'h300) begin mismatched++; $display("FAIL absorb_resume_addr: got %h want 300", imem_addr); end
    endtask

    task automatic test_wrap();
        logic [63:0] addr;
        bit          ok;
        exp_t        e;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        issue(32'h0010_0073, 64'hFFFF_FFFF_FFFF_FFFC, addr, ok);
        compared += 3;
        if (!ok) begin mismatched++; $display("FAIL wrap_req_timeout: got none want request"); end
        if (addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin mismatched++; $display("FAIL wrap_addr: got %h want fffffffffffffffc", addr); end
        if (ir_valid !== 1'b1) begin mismatched++; $display("FAIL wrap_ir_valid: got %b want 1", ir_valid); end
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++; $display("FAIL wrap_scoreboard: got empty want entry");
        end else begin
            e = exp_q.pop_front();
            compared += 2;
            if (ir !== e.instr) begin mismatched++; $display("FAIL wrap_ir: got %h want %h", ir, e.instr); end
            if (ir_pc !== e.pc) begin mismatched++; $display("FAIL wrap_ir_pc: got %h want %h", ir_pc, e.pc); end
        end
        last_ir = 32'h0010_0073;
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        compared += 2;
        if (imem_req_valid !== 1'b1) begin mismatched++; $display("FAIL wrap_next_req: got %b want 1", imem_req_valid); end
        if (imem_addr !== 64'h0) begin mismatched++; $display("FAIL wrap_next_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        logic [63:0] addr;
        bit          ok;
        exp_t        e;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h400;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        compared += 6;
        if (imem_req_valid !== 1'b0) begin mismatched++; $display("FAIL mid_rst_req: got %b want 0", imem_req_valid); end
        if (ir_valid !== 1'b0) begin mismatched++; $display("FAIL mid_rst_ir_valid: got %b want 0", ir_valid); end
        if (ir !== 32'h0000_0013) begin mismatched++; $display("FAIL mid_rst_ir: got %h want 00000013", ir); end
        if (ir_pc !== 64'h0) begin mismatched++; $display("FAIL mid_rst_ir_pc: got %h want 0", ir_pc); end
        if (imem_addr !== 64'h0) begin mismatched++; $display("FAIL mid_rst_addr: got %h want 0", imem_addr); end
        if (fetch_misalign !== 1'b0) begin mismatched++; $display("FAIL mid_rst_misalign: got %b want 0", fetch_misalign); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        issue(32'h0000_0517, 64'h0, addr, ok);
        compared += 3;
        if (!ok) begin mismatched++; $display("FAIL restart_req_timeout: got none want request"); end
        if (addr !== 64'h0) begin mismatched++; $display("FAIL restart_addr: got %h want 0", addr); end
        if (ir_valid !== 1'b1) begin mismatched++; $display("FAIL restart_ir_valid: got %b want 1", ir_valid); end
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++; $display("FAIL restart_scoreboard: got empty want entry");
        end else begin
            e = exp_q.pop_front();
            compared += 2;
            if (ir !== e.instr) begin mismatched++; $display("FAIL restart_ir: got %h want %h", ir, e.instr); end
            if (ir_pc !== e.pc) begin mismatched++; $display("FAIL restart_ir_pc: got %h want %h", ir_pc, e.pc); end
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        compared++;
        if (imem_addr !== 64'h4) begin mismatched++; $display("FAIL restart_next_addr: got %h want 4", imem_addr); end
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        last_ir        = 32'h0000_0013;
        test_reset();
        test_basic_fetch();
        test_back_to_back();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_misalign();
        test_wrap();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
